load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: data-memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_L, input, 1: reset, asynchronous and active-low.
REQ-005 Port lsu_req_valid, input, 1: request present.
REQ-006 Port lsu_req_ready, output, 1: request accepted when valid and ready are both 1.
REQ-007 Port lsu_req_store, input, 1: 1 = store, 0 = load.
REQ-008 Port lsu_req_funct3, input, 3: RV32I width code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-009 Port lsu_req_addr, input, ADDR_WIDTH+2: byte address.
REQ-010 Port lsu_req_wdata, input, 32: store data, right-justified.
REQ-011 Port lsu_resp_valid, output, 1: one-cycle completion pulse; no backpressure.
REQ-012 Port lsu_resp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-013 Port lsu_resp_err, output, 1: illegal funct3; valid with lsu_resp_valid.
REQ-014 Port dataMem_addr, output, ADDR_WIDTH: word address to data memory.
REQ-015 Port dataMem_in, output, 32: write data to data memory.
REQ-016 Port dataMem_WE_L, output, 4: active-low byte-lane write enables; lane i = bits 8i+7:8i.
REQ-017 Port dataMem_out, input, 32: combinational read data from data memory, same cycle as dataMem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, ACC0, ACC1 and SHALL assert lsu_req_ready only in IDLE.
REQ-019 On accept, the unit SHALL register store, funct3, addr and wdata, and move IDLE->ACC0.
REQ-020 In IDLE, the unit SHALL drive dataMem_WE_L=4'hF, dataMem_addr=0 and dataMem_in=0.
REQ-021 Let o = addr[1:0], w = addr[ADDR_WIDTH+1:2] and size = 1/2/4 bytes. ACC0 SHALL drive dataMem_addr=w; ACC1 SHALL drive (w+1) mod 2^ADDR_WIDTH.
REQ-022 An access SHALL be split when o+size>4; ACC0 then goes to ACC1, otherwise ACC0 goes to IDLE. ACC1 SHALL always go to IDLE.
REQ-023 In ACC0 and ACC1, dataMem_in SHALL equal lsu_req_wdata rotated left by 8*o bits.
REQ-024 Store lane enables: ACC0 SHALL enable lanes o..min(o+size,4)-1, and ACC1 SHALL enable lanes 0..o+size-5. Enabled lanes are 0 and all other lanes are 1.
REQ-025 Loads SHALL keep dataMem_WE_L=4'hF in every state.
REQ-026 Loads SHALL capture dataMem_out in ACC0 (word0) and in ACC1 (word1).
REQ-027 Load result: take {word1, word0} >> 8*o, keep the low size bytes, then sign-extend (LB, LH) or zero-extend (LBU, LHU, LW).
REQ-028 Illegal funct3 (load 3, 6, 7; store 3-7) SHALL take ACC0 with WE_L=4'hF and no split, then respond with err=1 and rdata=0.
REQ-029 lsu_resp_valid SHALL be registered and asserted in the cycle after the final access state.
REQ-030 Latency SHALL be 2 cycles (unsplit) or 3 cycles (split) from the accept edge to lsu_resp_valid.
REQ-031 A new request MAY be accepted in the same cycle lsu_resp_valid is high; back-to-back throughput is one access per 2 cycles (unsplit).
REQ-032 Word-address wrap: a split access at w = 2^ADDR_WIDTH-1 SHALL use word 0 in ACC1.

Reset
REQ-033 While reset_L=0, the unit SHALL hold: state IDLE, lsu_req_ready=1, lsu_resp_valid=0, lsu_resp_rdata=0, lsu_resp_err=0, dataMem_WE_L=4'hF, dataMem_addr=0, dataMem_in=0.
REQ-034 Reset asserted in ACC0 or ACC1 SHALL abort the access immediately with no response; a first-word store already committed SHALL remain committed.

Structure
REQ-035 Package lsu_pkg SHALL hold the state enum, funct3 constants and WE_NONE=4'hF.
REQ-036 Sub-module lsu_align SHALL be combinational and SHALL do the store rotate, lane-mask generation and load extract/extend.

Verification
REQ-037 SW addr 0x010, wdata 0xDEADBEEF -> ACC0: addr 4, WE_L 4'h0; resp at +2 cycles with rdata 0.
REQ-038 LB addr 0x013, mem word4 = 0x80112233 -> rdata 0xFFFFFF80; LBU same address -> 0x00000080.
REQ-039 SH addr 0x007, wdata 0x0000A1B2 -> ACC0: word1, WE_L 4'h7, din 0xB2..; ACC1: word2, WE_L 4'hE; resp at +3 cycles.
REQ-040 LW addr 0x3FFE, mem[0xFFF]=0x44332211, mem[0]=0x88776655 -> ACC1 addr 0; rdata 0x66554433.
REQ-041 Load with funct3=3 -> WE_L stays 4'hF; resp at +2 cycles with err=1, rdata=0.
REQ-042 Split SW with reset_L pulled low during ACC1 -> WE_L=4'hF asynchronously, no resp, ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, RV32I width codes,
// idle write-enable value and width/legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] WE_NONE = 4'hF;

  function automatic logic f3_legal(
    input logic       store,
    input logic [2:0] f3
  );
    if (store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Active-high lane mask for the access size, lane 0 aligned
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment: store rotate, two-word lane masks,
// split detect and load extract with sign/zero extension.
// Ports: legal_i/funct3_i/off_i/wdata_i/word0_i/word1_i in;
//        wrot_o, lane0_o, lane1_o, split_o, rdata_o out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        legal_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  output logic [31:0] wrot_o,
  output logic [3:0]  lane0_o,
  output logic [3:0]  lane1_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [7:0]  span;
  logic [63:0] dbl;
  logic [63:0] pair;
  logic [31:0] raw;

  assign sh = {off_i, 3'b000};

  // Lanes past 3 spill into the next word
  assign span = legal_i
              ? ({4'b0000, size_mask(funct3_i)} << off_i)
              : 8'h00;
  assign lane0_o = span[3:0];
  assign lane1_o = span[7:4];
  assign split_o = |span[7:4];

  // Upper half of a doubled word shifted left is a rotate
  assign dbl    = {wdata_i, wdata_i} << sh;
  assign wrot_o = dbl[63:32];

  assign pair = {word1_i, word0_i} >> sh;
  assign raw  = pair[31:0];

  always_comb begin
    rdata_o = raw;
    case (funct3_i)
      F3_B:  rdata_o = {{24{raw[7]}}, raw[7:0]};
      F3_H:  rdata_o = {{16{raw[15]}}, raw[15:0]};
      F3_BU: rdata_o = {24'h0, raw[7:0]};
      F3_HU: rdata_o = {16'h0, raw[15:0]};
      default: rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, misaligned
// accesses split over two consecutive data-memory words.
// Ports: clock/reset_L, lsu_req_* handshake in, lsu_resp_* out,
//        dataMem_* word-addressed memory with byte-lane WE_L.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_store,
  input  logic [2:0]            lsu_req_funct3,
  input  logic [ADDR_WIDTH+1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  lsu_resp_err,
  output logic [ADDR_WIDTH-1:0] dataMem_addr,
  output logic [DATA_WIDTH-1:0] dataMem_in,
  output logic [3:0]            dataMem_WE_L,
  input  logic [DATA_WIDTH-1:0] dataMem_out
);

  state_e                state_q;
  logic                  store_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           word0_q;
  logic                  resp_valid_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic                  legal;
  logic [ADDR_WIDTH-1:0] w;
  logic [31:0]           word0;
  logic [31:0]           wrot;
  logic [3:0]            lane0;
  logic [3:0]            lane1;
  logic                  split;
  logic [31:0]           ext;

  assign legal = f3_legal(store_q, f3_q);
  assign w     = addr_q[ADDR_WIDTH+1:2];
  // First word is still on the bus when an unsplit load finishes
  assign word0 = (state_q == ACC0) ? dataMem_out : word0_q;

  lsu_align u_align (
    .legal_i  (legal),
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .word0_i  (word0),
    .word1_i  (dataMem_out),
    .wrot_o   (wrot),
    .lane0_o  (lane0),
    .lane1_o  (lane1),
    .split_o  (split),
    .rdata_o  (ext)
  );

  always_comb begin
    dataMem_addr = '0;
    dataMem_in   = '0;
    dataMem_WE_L = WE_NONE;
    case (state_q)
      ACC0: begin
        dataMem_addr = w;
        dataMem_in   = wrot;
        if (store_q) dataMem_WE_L = ~lane0;
      end
      ACC1: begin
        dataMem_addr = w + 1'b1;
        dataMem_in   = wrot;
        if (store_q) dataMem_WE_L = ~lane1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word0_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_req_valid) begin
            store_q <= lsu_req_store;
            f3_q    <= lsu_req_funct3;
            addr_q  <= lsu_req_addr;
            wdata_q <= lsu_req_wdata;
            state_q <= ACC0;
          end
        end
        ACC0: begin
          word0_q <= dataMem_out;
          if (split) begin
            state_q <= ACC1;
          end else begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b1;
            err_q        <= ~legal;
            rdata_q      <= (store_q || !legal) ? '0 : ext;
          end
        end
        ACC1: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          err_q        <= ~legal;
          rdata_q      <= (store_q || !legal) ? '0 : ext;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_req_ready  = (state_q == IDLE);
  assign lsu_resp_valid = resp_valid_q;
  assign lsu_resp_rdata = rdata_q;
  assign lsu_resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural
// byte-lane data memory; one task per scenario.
module tb_load_store_unit;

  logic        clock;
  logic        reset_L;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_store;
  logic [2:0]  lsu_req_funct3;
  logic [13:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic [11:0] dataMem_addr;
  logic [31:0] dataMem_in;
  logic [3:0]  dataMem_WE_L;
  logic [31:0] dataMem_out;

  logic [31:0] mem [0:4095];
  int passed = 0;
  int total  = 0;

  load_store_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock          (clock),
    .reset_L        (reset_L),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_store  (lsu_req_store),
    .lsu_req_funct3 (lsu_req_funct3),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .dataMem_addr   (dataMem_addr),
    .dataMem_in     (dataMem_in),
    .dataMem_WE_L   (dataMem_WE_L),
    .dataMem_out    (dataMem_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dataMem_out = mem[dataMem_addr];

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (!dataMem_WE_L[i]) mem[dataMem_addr][8*i +: 8] <= dataMem_in[8*i +: 8];
  end

  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [13:0] a, input logic [31:0] d);
    @(negedge clock);
    lsu_req_valid  = 1'b1;
    lsu_req_store  = st;
    lsu_req_funct3 = f3;
    lsu_req_addr   = a;
    lsu_req_wdata  = d;
    @(posedge clock);
    #1;
    lsu_req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_store = 1'b0;
    lsu_req_funct3 = 3'd0;
    lsu_req_addr = '0;
    lsu_req_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (lsu_req_ready !== 1'b1) $display("FAIL rst_ready got %h want 1", lsu_req_ready); else passed++;
    total++; if (lsu_resp_valid !== 1'b0) $display("FAIL rst_rvalid got %h want 0", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", lsu_resp_rdata); else passed++;
    total++; if (lsu_resp_err !== 1'b0) $display("FAIL rst_err got %h want 0", lsu_resp_err); else passed++;
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL rst_we got %h want f", dataMem_WE_L); else passed++;
    total++; if (dataMem_addr !== 12'h0) $display("FAIL rst_addr got %h want 0", dataMem_addr); else passed++;
    total++; if (dataMem_in !== 32'h0) $display("FAIL rst_din got %h want 0", dataMem_in); else passed++;
    @(negedge clock);
    reset_L = 1'b1;
  endtask

  task automatic test_sw;
    issue(1'b1, 3'd2, 14'h010, 32'hDEADBEEF);
    total++; if (dataMem_addr !== 12'h004) $display("FAIL sw_addr got %h want 004", dataMem_addr); else passed++;
    total++; if (dataMem_WE_L !== 4'h0) $display("FAIL sw_we got %h want 0", dataMem_WE_L); else passed++;
    total++; if (dataMem_in !== 32'hDEADBEEF) $display("FAIL sw_din got %h want deadbeef", dataMem_in); else passed++;
    total++; if (lsu_req_ready !== 1'b0) $display("FAIL sw_busy got %h want 0", lsu_req_ready); else passed++;
    total++; if (lsu_resp_valid !== 1'b0) $display("FAIL sw_early got %h want 0", lsu_resp_valid); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL sw_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'h0) $display("FAIL sw_rdata got %h want 0", lsu_resp_rdata); else passed++;
    total++; if (lsu_resp_err !== 1'b0) $display("FAIL sw_err got %h want 0", lsu_resp_err); else passed++;
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL sw_idle_we got %h want f", dataMem_WE_L); else passed++;
    total++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_mem got %h want deadbeef", mem[4]); else passed++;
  endtask

  task automatic test_load_ext;
    @(negedge clock);
    mem[4] = 32'h80112233;
    issue(1'b0, 3'd0, 14'h013, 32'h0);
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL lb_we got %h want f", dataMem_WE_L); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL lb_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata got %h want ffffff80", lsu_resp_rdata); else passed++;
    issue(1'b0, 3'd4, 14'h013, 32'h0);
    @(posedge clock); #1;
    total++; if (lsu_resp_rdata !== 32'h00000080) $display("FAIL lbu_rdata got %h want 00000080", lsu_resp_rdata); else passed++;
    issue(1'b0, 3'd1, 14'h012, 32'h0);
    @(posedge clock); #1;
    total++; if (lsu_resp_rdata !== 32'hFFFF8011) $display("FAIL lh_rdata got %h want ffff8011", lsu_resp_rdata); else passed++;
    issue(1'b0, 3'd5, 14'h011, 32'h0);
    @(posedge clock); #1;
    total++; if (lsu_resp_rdata !== 32'h00001122) $display("FAIL lhu_rdata got %h want 00001122", lsu_resp_rdata); else passed++;
  endtask

  task automatic test_sh_split;
    @(negedge clock);
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    issue(1'b1, 3'd1, 14'h007, 32'h0000A1B2);
    total++; if (dataMem_addr !== 12'h001) $display("FAIL sh_a0 got %h want 001", dataMem_addr); else passed++;
    total++; if (dataMem_WE_L !== 4'h7) $display("FAIL sh_we0 got %h want 7", dataMem_WE_L); else passed++;
    total++; if (dataMem_in !== 32'hB20000A1) $display("FAIL sh_din got %h want b20000a1", dataMem_in); else passed++;
    @(posedge clock); #1;
    total++; if (dataMem_addr !== 12'h002) $display("FAIL sh_a1 got %h want 002", dataMem_addr); else passed++;
    total++; if (dataMem_WE_L !== 4'hE) $display("FAIL sh_we1 got %h want e", dataMem_WE_L); else passed++;
    total++; if (lsu_resp_valid !== 1'b0) $display("FAIL sh_early got %h want 0", lsu_resp_valid); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL sh_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (mem[1] !== 32'hB2111111) $display("FAIL sh_mem1 got %h want b2111111", mem[1]); else passed++;
    total++; if (mem[2] !== 32'h222222A1) $display("FAIL sh_mem2 got %h want 222222a1", mem[2]); else passed++;
  endtask

  task automatic test_lw_wrap;
    @(negedge clock);
    mem[4095] = 32'h44332211;
    mem[0]    = 32'h88776655;
    issue(1'b0, 3'd2, 14'h3FFE, 32'h0);
    total++; if (dataMem_addr !== 12'hFFF) $display("FAIL wrap_a0 got %h want fff", dataMem_addr); else passed++;
    @(posedge clock); #1;
    total++; if (dataMem_addr !== 12'h000) $display("FAIL wrap_a1 got %h want 000", dataMem_addr); else passed++;
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL wrap_we got %h want f", dataMem_WE_L); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL wrap_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'h66554433) $display("FAIL wrap_rdata got %h want 66554433", lsu_resp_rdata); else passed++;
  endtask

  task automatic test_illegal;
    issue(1'b0, 3'd3, 14'h010, 32'h0);
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL ill_ld_we got %h want f", dataMem_WE_L); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL ill_ld_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_err !== 1'b1) $display("FAIL ill_ld_err got %h want 1", lsu_resp_err); else passed++;
    total++; if (lsu_resp_rdata !== 32'h0) $display("FAIL ill_ld_rdata got %h want 0", lsu_resp_rdata); else passed++;
    issue(1'b1, 3'd4, 14'h007, 32'hFFFFFFFF);
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL ill_st_we got %h want f", dataMem_WE_L); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL ill_st_rvalid got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_err !== 1'b1) $display("FAIL ill_st_err got %h want 1", lsu_resp_err); else passed++;
    total++; if (mem[1] !== 32'hB2111111) $display("FAIL ill_st_mem got %h want b2111111", mem[1]); else passed++;
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    mem[4] = 32'hDEADBEEF;
    issue(1'b0, 3'd2, 14'h010, 32'h0);
    lsu_req_valid  = 1'b1;
    lsu_req_funct3 = 3'd5;
    lsu_req_addr   = 14'h002;
    total++; if (lsu_req_ready !== 1'b0) $display("FAIL b2b_busy got %h want 0", lsu_req_ready); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL b2b_rv1 got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'hDEADBEEF) $display("FAIL b2b_rd1 got %h want deadbeef", lsu_resp_rdata); else passed++;
    total++; if (lsu_req_ready !== 1'b1) $display("FAIL b2b_ready got %h want 1", lsu_req_ready); else passed++;
    @(posedge clock); #1;
    lsu_req_valid = 1'b0;
    total++; if (lsu_req_ready !== 1'b0) $display("FAIL b2b_acc2 got %h want 0", lsu_req_ready); else passed++;
    total++; if (dataMem_addr !== 12'h000) $display("FAIL b2b_a2 got %h want 000", dataMem_addr); else passed++;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b1) $display("FAIL b2b_rv2 got %h want 1", lsu_resp_valid); else passed++;
    total++; if (lsu_resp_rdata !== 32'h00008877) $display("FAIL b2b_rd2 got %h want 00008877", lsu_resp_rdata); else passed++;
  endtask

  task automatic test_reset_abort;
    @(negedge clock);
    mem[9]  = 32'h0;
    mem[10] = 32'h0;
    issue(1'b1, 3'd2, 14'h025, 32'h01020304);
    total++; if (dataMem_WE_L !== 4'h1) $display("FAIL ab_we0 got %h want 1", dataMem_WE_L); else passed++;
    total++; if (dataMem_in !== 32'h02030401) $display("FAIL ab_din got %h want 02030401", dataMem_in); else passed++;
    @(posedge clock); #1;
    total++; if (dataMem_WE_L !== 4'hE) $display("FAIL ab_we1 got %h want e", dataMem_WE_L); else passed++;
    reset_L = 1'b0;
    #1;
    total++; if (dataMem_WE_L !== 4'hF) $display("FAIL ab_async_we got %h want f", dataMem_WE_L); else passed++;
    total++; if (dataMem_addr !== 12'h000) $display("FAIL ab_async_addr got %h want 000", dataMem_addr); else passed++;
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock); #1;
    total++; if (lsu_resp_valid !== 1'b0) $display("FAIL ab_noresp got %h want 0", lsu_resp_valid); else passed++;
    total++; if (lsu_req_ready !== 1'b1) $display("FAIL ab_ready got %h want 1", lsu_req_ready); else passed++;
    total++; if (mem[9] !== 32'h02030400) $display("FAIL ab_mem9 got %h want 02030400", mem[9]); else passed++;
    total++; if (mem[10] !== 32'h0) $display("FAIL ab_mem10 got %h want 0", mem[10]); else passed++;
  endtask

  initial begin
    test_reset;
    test_sw;
    test_load_ext;
    test_sh_split;
    test_lw_wrap;
    test_illegal;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
